// File: rtl/rv_pkg.sv
// Shared register-file constants and types used by the writeback controller.
package rv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;

  typedef logic [AW-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_LOAD
  } wb_src_e;

endpackage

// File: rtl/ld_pend_fifo.sv
// In-order FIFO of outstanding load destination registers; exposes every
// entry and its valid bit so the controller can detect load-use hazards.
module ld_pend_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [AW-1:0]            rd_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [AW-1:0]            head_o,
  output logic [DEPTH-1:0][AW-1:0] ent_rd_o,
  output logic [DEPTH-1:0]         ent_vld_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [PW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic [DEPTH-1:0][AW-1:0] rd_q, rd_d;
  logic [DEPTH-1:0]         vld_q, vld_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign head_o    = rd_q[rd_ptr_q];
  assign ent_rd_o  = rd_q;
  assign ent_vld_o = vld_q;

  // Pop clears before push sets, so a push/pop at full into the same slot keeps it valid.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rd_d     = rd_q;
    vld_d    = vld_q;
    if (pop_i) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = ptr_inc(rd_ptr_q);
    end
    if (push_i) begin
      vld_d[wr_ptr_q] = 1'b1;
      rd_d[wr_ptr_q]  = rd_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (push_i && !pop_i) begin
      count_d = count_q + 1'b1;
    end else if (pop_i && !push_i) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rd_q     <= '0;
      vld_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rd_q     <= rd_d;
      vld_q    <= vld_d;
    end
  end

endmodule

// File: rtl/reg_wb_ctrl.sv
// Register-file write port controller merging ALU and load writebacks.
// Optional macro WB_BYPASS_EN adds registered read-during-write bypass outputs.
module reg_wb_ctrl
  import rv_pkg::*;
#(
  parameter int unsigned XLEN     = rv_pkg::XLEN,
  parameter int unsigned LD_DEPTH = 2,
  parameter int unsigned AW       = rv_pkg::AW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_wr_i,
  input  logic [AW-1:0]   alu_waddr_i,
  input  logic [XLEN-1:0] alu_wdata_i,
  input  logic            ld_issue_i,
  input  logic [AW-1:0]   ld_rd_i,
  output logic            ld_full_o,
  input  logic            ld_rsp_valid_i,
  input  logic [XLEN-1:0] ld_rsp_data_i,
  output logic            ld_rsp_ready_o,
  input  logic [AW-1:0]   raddr_1_i,
  input  logic [AW-1:0]   raddr_2_i,
  output logic            stall_o,
  output logic            reg_wr_c_o,
  output logic [AW-1:0]   waddr_o,
  output logic [XLEN-1:0] wdata_o,
  output logic            err_o
`ifdef WB_BYPASS_EN
  ,
  output logic            byp_1_o,
  output logic            byp_2_o,
  output logic [XLEN-1:0] byp_data_o
`endif
);

  logic                        empty, push, pop;
  logic [AW-1:0]               head_rd;
  logic [LD_DEPTH-1:0][AW-1:0] ent_rd;
  logic [LD_DEPTH-1:0]         ent_vld;
  logic                        err_q, err_d;
  wb_src_e                     src;

  assign ld_rsp_ready_o = ~alu_wr_i & ~empty;
  assign pop            = ld_rsp_valid_i & ld_rsp_ready_o;
  // A pop in the same cycle frees a slot, so issuing at full is legal then.
  assign push           = ld_issue_i & (~ld_full_o | pop);

  ld_pend_fifo #(
    .DEPTH (LD_DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (push),
    .rd_i      (ld_rd_i),
    .pop_i     (pop),
    .full_o    (ld_full_o),
    .empty_o   (empty),
    .head_o    (head_rd),
    .ent_rd_o  (ent_rd),
    .ent_vld_o (ent_vld)
  );

  always_comb begin
    src = WB_NONE;
    if (alu_wr_i) begin
      src = WB_ALU;
    end else if (pop) begin
      src = WB_LOAD;
    end
  end

  always_comb begin
    waddr_o = '0;
    wdata_o = '0;
    unique case (src)
      WB_ALU: begin
        waddr_o = alu_waddr_i;
        wdata_o = alu_wdata_i;
      end
      WB_LOAD: begin
        waddr_o = head_rd;
        wdata_o = ld_rsp_data_i;
      end
      default: ;
    endcase
  end

  assign reg_wr_c_o = (src != WB_NONE) && (waddr_o != '0);

  always_comb begin
    stall_o = 1'b0;
    for (int unsigned i = 0; i < LD_DEPTH; i++) begin
      if (ent_vld[i] && (raddr_1_i != '0) && (ent_rd[i] == raddr_1_i)) stall_o = 1'b1;
      if (ent_vld[i] && (raddr_2_i != '0) && (ent_rd[i] == raddr_2_i)) stall_o = 1'b1;
    end
`ifndef WB_BYPASS_EN
    if (reg_wr_c_o && (raddr_1_i != '0) && (waddr_o == raddr_1_i)) stall_o = 1'b1;
    if (reg_wr_c_o && (raddr_2_i != '0) && (waddr_o == raddr_2_i)) stall_o = 1'b1;
`endif
  end

  assign err_d = err_q
               | (ld_issue_i & ld_full_o & ~pop)
               | (ld_rsp_valid_i & empty);
  assign err_o = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

`ifdef WB_BYPASS_EN
  logic            byp_1_q, byp_1_d, byp_2_q, byp_2_d;
  logic [XLEN-1:0] byp_data_q, byp_data_d;

  always_comb begin
    byp_1_d    = reg_wr_c_o && (raddr_1_i != '0) && (waddr_o == raddr_1_i);
    byp_2_d    = reg_wr_c_o && (raddr_2_i != '0) && (waddr_o == raddr_2_i);
    byp_data_d = reg_wr_c_o ? wdata_o : byp_data_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byp_1_q    <= 1'b0;
      byp_2_q    <= 1'b0;
      byp_data_q <= '0;
    end else begin
      byp_1_q    <= byp_1_d;
      byp_2_q    <= byp_2_d;
      byp_data_q <= byp_data_d;
    end
  end

  assign byp_1_o    = byp_1_q;
  assign byp_2_o    = byp_2_q;
  assign byp_data_o = byp_data_q;
`endif

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Directed self-checking bench for reg_wb_ctrl with hand-computed expectations.
module tb_reg_wb_ctrl;

  logic        clk;
  logic        reset;
  logic        alu_wr_i;
  logic [4:0]  alu_waddr_i;
  logic [31:0] alu_wdata_i;
  logic        ld_issue_i;
  logic [4:0]  ld_rd_i;
  logic        ld_full_o;
  logic        ld_rsp_valid_i;
  logic [31:0] ld_rsp_data_i;
  logic        ld_rsp_ready_o;
  logic [4:0]  raddr_1_i;
  logic [4:0]  raddr_2_i;
  logic        stall_o;
  logic        reg_wr_c_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;
  logic        err_o;
`ifdef WB_BYPASS_EN
  logic        byp_1_o;
  logic        byp_2_o;
  logic [31:0] byp_data_o;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  reg_wb_ctrl #(
    .XLEN     (32),
    .LD_DEPTH (2),
    .AW       (5)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .alu_wr_i       (alu_wr_i),
    .alu_waddr_i    (alu_waddr_i),
    .alu_wdata_i    (alu_wdata_i),
    .ld_issue_i     (ld_issue_i),
    .ld_rd_i        (ld_rd_i),
    .ld_full_o      (ld_full_o),
    .ld_rsp_valid_i (ld_rsp_valid_i),
    .ld_rsp_data_i  (ld_rsp_data_i),
    .ld_rsp_ready_o (ld_rsp_ready_o),
    .raddr_1_i      (raddr_1_i),
    .raddr_2_i      (raddr_2_i),
    .stall_o        (stall_o),
    .reg_wr_c_o     (reg_wr_c_o),
    .waddr_o        (waddr_o),
    .wdata_o        (wdata_o),
    .err_o          (err_o)
`ifdef WB_BYPASS_EN
    ,
    .byp_1_o        (byp_1_o),
    .byp_2_o        (byp_2_o),
    .byp_data_o     (byp_data_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change at posedge+1, checks happen at posedge+3.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    alu_wr_i       = 1'b0;
    alu_waddr_i    = '0;
    alu_wdata_i    = '0;
    ld_issue_i     = 1'b0;
    ld_rd_i        = '0;
    ld_rsp_valid_i = 1'b0;
    ld_rsp_data_i  = '0;
    raddr_1_i      = '0;
    raddr_2_i      = '0;
  endtask

  task automatic issue(input logic [4:0] rd);
    ld_issue_i = 1'b1;
    ld_rd_i    = rd;
    tick();
    ld_issue_i = 1'b0;
    ld_rd_i    = '0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    #12;
    check("rst_full",  32'(ld_full_o), 32'd0);
    check("rst_err",   32'(err_o), 32'd0);
    check("rst_wr",    32'(reg_wr_c_o), 32'd0);
    check("rst_ready", 32'(ld_rsp_ready_o), 32'd0);
    check("rst_waddr", 32'(waddr_o), 32'd0);
    check("rst_wdata", wdata_o, 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    reset = 1'b1;
    tick();

    // ALU write and x0 drop
    alu_wr_i = 1'b1; alu_waddr_i = 5'd5; alu_wdata_i = 32'hDEADBEEF; raddr_1_i = 5'd5;
    settle();
    check("alu_wr",    32'(reg_wr_c_o), 32'd1);
    check("alu_waddr", 32'(waddr_o), 32'd5);
    check("alu_wdata", wdata_o, 32'hDEADBEEF);
`ifndef WB_BYPASS_EN
    check("alu_rdw_stall", 32'(stall_o), 32'd1);
`endif
    tick();
    alu_waddr_i = 5'd0; alu_wdata_i = 32'h0BADF00D; raddr_1_i = 5'd0;
    settle();
    check("alu_x0_wr", 32'(reg_wr_c_o), 32'd0);
    tick();
    idle_inputs();

    // Load-use stall on x7
    issue(5'd7);
    raddr_1_i = 5'd7;
    settle();
    check("ld7_stall",  32'(stall_o), 32'd1);
    check("ld7_ready",  32'(ld_rsp_ready_o), 32'd1);
    check("ld7_nowr",   32'(reg_wr_c_o), 32'd0);
    tick();
    check("ld7_stall_wait", 32'(stall_o), 32'd1);
    ld_rsp_valid_i = 1'b1; ld_rsp_data_i = 32'h12345678;
    settle();
    check("ld7_wr",    32'(reg_wr_c_o), 32'd1);
    check("ld7_waddr", 32'(waddr_o), 32'd7);
    check("ld7_wdata", wdata_o, 32'h12345678);
    check("ld7_stall_acc", 32'(stall_o), 32'd1);
    tick();
    ld_rsp_valid_i = 1'b0;
    settle();
    check("ld7_stall_after", 32'(stall_o), 32'd0);
    check("ld7_ready_after", 32'(ld_rsp_ready_o), 32'd0);
    tick();
    idle_inputs();

    // ALU beats a concurrent load response
    issue(5'd9);
    ld_rsp_valid_i = 1'b1; ld_rsp_data_i = 32'hAAAA5555;
    alu_wr_i = 1'b1; alu_waddr_i = 5'd3; alu_wdata_i = 32'h00000033;
    settle();
    check("mix_waddr", 32'(waddr_o), 32'd3);
    check("mix_wdata", wdata_o, 32'h00000033);
    check("mix_ready", 32'(ld_rsp_ready_o), 32'd0);
    tick();
    alu_wr_i = 1'b0; alu_waddr_i = '0; alu_wdata_i = '0;
    settle();
    check("mix_ld_wr",    32'(reg_wr_c_o), 32'd1);
    check("mix_ld_waddr", 32'(waddr_o), 32'd9);
    check("mix_ld_wdata", wdata_o, 32'hAAAA5555);
    tick();
    idle_inputs();

    // Load to x0: no stall, write dropped
    issue(5'd0);
    raddr_2_i = 5'd0; raddr_1_i = 5'd1;
    settle();
    check("x0_stall", 32'(stall_o), 32'd0);
    ld_rsp_valid_i = 1'b1; ld_rsp_data_i = 32'hCAFEF00D;
    settle();
    check("x0_wr",    32'(reg_wr_c_o), 32'd0);
    check("x0_ready", 32'(ld_rsp_ready_o), 32'd1);
    tick();
    idle_inputs();

    // Push and pop at full, pointers wrap
    issue(5'd1);
    issue(5'd2);
    settle();
    check("wrap_full", 32'(ld_full_o), 32'd1);
    ld_issue_i = 1'b1; ld_rd_i = 5'd4;
    ld_rsp_valid_i = 1'b1; ld_rsp_data_i = 32'h00000011;
    settle();
    check("wrap_waddr1", 32'(waddr_o), 32'd1);
    tick();
    ld_issue_i = 1'b0; ld_rd_i = '0;
    ld_rsp_valid_i = 1'b0;
    settle();
    check("wrap_full_kept", 32'(ld_full_o), 32'd1);
    check("wrap_noerr",     32'(err_o), 32'd0);
    raddr_2_i = 5'd4;
    settle();
    check("wrap_stall4", 32'(stall_o), 32'd1);
    raddr_2_i = '0;
    ld_rsp_valid_i = 1'b1; ld_rsp_data_i = 32'h00000022;
    settle();
    check("wrap_waddr2", 32'(waddr_o), 32'd2);
    tick();
    ld_rsp_data_i = 32'h00000044;
    settle();
    check("wrap_waddr4", 32'(waddr_o), 32'd4);
    check("wrap_wdata4", wdata_o, 32'h00000044);
    tick();
    idle_inputs();
    settle();
    check("wrap_empty_ready", 32'(ld_rsp_ready_o), 32'd0);

    // Overflow: third issue dropped and flagged
    issue(5'd1);
    issue(5'd2);
    issue(5'd3);
    settle();
    check("ovf_err",  32'(err_o), 32'd1);
    check("ovf_full", 32'(ld_full_o), 32'd1);
    raddr_1_i = 5'd3;
    settle();
    check("ovf_no_stall3", 32'(stall_o), 32'd0);
    raddr_1_i = '0;
    ld_rsp_valid_i = 1'b1; ld_rsp_data_i = 32'h00000101;
    settle();
    check("ovf_waddr1", 32'(waddr_o), 32'd1);
    tick();
    ld_rsp_data_i = 32'h00000202;
    settle();
    check("ovf_waddr2", 32'(waddr_o), 32'd2);
    tick();
    idle_inputs();
    settle();
    check("ovf_drained", 32'(ld_rsp_ready_o), 32'd0);

    // Reset with two loads pending
    issue(5'd1);
    issue(5'd2);
    raddr_1_i = 5'd1;
    settle();
    check("prerst_stall", 32'(stall_o), 32'd1);
    reset = 1'b0;
    settle();
    check("midrst_full",  32'(ld_full_o), 32'd0);
    check("midrst_stall", 32'(stall_o), 32'd0);
    check("midrst_err",   32'(err_o), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    ld_rsp_valid_i = 1'b1; ld_rsp_data_i = 32'h5A5A5A5A;
    settle();
    check("late_rsp_wr",    32'(reg_wr_c_o), 32'd0);
    check("late_rsp_ready", 32'(ld_rsp_ready_o), 32'd0);
    tick();
    ld_rsp_valid_i = 1'b0;
    settle();
    check("late_rsp_err", 32'(err_o), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/reg_wb_ctrl.md
Name: reg_wb_ctrl

Overview:
- Writer-side controller for the 32x32 integer register file. It owns the single write port (write enable, address, data).
- Merges two write sources: single-cycle ALU/CSR results and late-returning load responses.
- Tracks outstanding loads in an in-order pending FIFO and raises a load-use stall for the decode/read stage.
- Sits between the execute/memory stages and the register file.

Parameters:
- XLEN, 32, data width of register file and write data.
- LD_DEPTH, 2, maximum outstanding loads; power of two, ≥1.
- AW, 5, register address width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- alu_wr_i  in  1  ALU/CSR writeback valid this cycle; cannot be stalled.
- alu_waddr_i  in  AW  ALU destination register.
- alu_wdata_i  in  XLEN  ALU result.
- ld_issue_i  in  1  load issued to memory this cycle.
- ld_rd_i  in  AW  destination register of the issued load.
- ld_full_o  out  1  pending FIFO full; issuing is illegal.
- ld_rsp_valid_i  in  1  load data valid, in issue order.
- ld_rsp_data_i  in  XLEN  load data.
- ld_rsp_ready_o  out  1  load response accepted when valid and ready.
- raddr_1_i  in  AW  decode-stage read address 1.
- raddr_2_i  in  AW  decode-stage read address 2.
- stall_o  out  1  hold decode; a read operand is not yet valid.
- reg_wr_c_o  out  1  register file write enable.
- waddr_o  out  AW  register file write address.
- wdata_o  out  XLEN  register file write data.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset (async, reset=0): pending FIFO empty (wr_ptr=rd_ptr=0, count=0), err_o=0. All registered state cleared; combinational outputs follow from the empty state.
- Write port (combinational):
  - If alu_wr_i=1, the ALU write wins: waddr_o=alu_waddr_i, wdata_o=alu_wdata_i.
  - Otherwise, if a load response is accepted, waddr_o=head rd and wdata_o=ld_rsp_data_i.
  - reg_wr_c_o=1 only when the selected waddr_o≠0; x0 writes are dropped.
  - When idle, waddr_o=0 and wdata_o=0.
- ld_rsp_ready_o = ~alu_wr_i & (count≠0). The memory side holds data until accepted. Zero added latency: the write lands at the same edge as acceptance.
- Pending FIFO:
  - Push on ld_issue_i & ~ld_full_o (rd stored, including rd=0).
  - Pop on ld_rsp_valid_i & ld_rsp_ready_o.
  - Simultaneous push and pop at full is legal: count unchanged, pointers both advance, wrap modulo LD_DEPTH.
  - ld_full_o = (count==LD_DEPTH).
- Errors (set err_o, clear only by reset):
  - ld_issue_i while ld_full_o=1 and no pop that cycle: push dropped.
  - ld_rsp_valid_i with count==0: response ignored.
- stall_o = 1 when raddr_k≠0 (k=1 or 2) and any of the following holds:
  - raddr_k equals any valid pending-FIFO rd, including the entry completing this cycle;
  - raddr_k equals waddr_o while reg_wr_c_o=1 (read-during-write returns stale data; see optional feature).
- Stall is combinational; the upstream stage re-presents the same raddr next cycle.
- A load to x0 never causes a stall.
- Reset mid-operation: pending entries are discarded. Responses arriving after reset release raise err_o.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - Adds outputs byp_1_o, byp_2_o (1 bit each) and byp_data_o (XLEN), all registered, reset to 0.
  - byp_k_o=1 on the cycle after a write whose address matched raddr_k≠0; byp_data_o holds that written data.
  - The same-cycle write match is removed from the stall_o condition. Pending-FIFO matches still stall.
- Undefined: ports absent; stall_o includes the write-port match.

Decomposition:
- Shared package rv_pkg:
  - XLEN and AW constants.
  - typedef reg_addr_t (logic [AW-1:0]).
  - typedef wb_src_e {WB_NONE, WB_ALU, WB_LOAD}, used for the internal mux select.
- One sub-module: ld_pend_fifo, a parameterised rd-address FIFO with push/pop/full/empty and a per-entry valid vector exposed for the stall comparison.

Test Plan:
- ALU write x5=0xDEADBEEF, no loads -> reg_wr_c_o=1, waddr_o=5, wdata_o=0xDEADBEEF same cycle; alu_waddr_i=0 -> reg_wr_c_o=0.
- Issue load rd=7; raddr_1_i=7 -> stall_o=1 until response 0x12345678 is accepted; stall_o=0 the next cycle, and the write lands at x7.
- Load response and alu_wr_i (x3) in the same cycle -> x3 written, ld_rsp_ready_o=0; load written the following cycle with the same data.
- LD_DEPTH=2: issue rd=1, rd=2, then rd=3 with no pop -> ld_full_o=1, third push dropped, err_o=1; responses written in order to x1, then x2.
- At full, issue rd=4 together with accepting a response -> count stays 2, no error, after wrap the next responses target x2, then x4.
- Reset asserted with 2 pending loads -> ld_full_o=0, stall_o=0 for raddr=1; a subsequent response -> err_o=1, no write.
